// File: rtl/sipo_ctrl.sv
// Serial-in/parallel-out controller with an IDLE/SHIFT session FSM.
// Completed words go to a valid/ready output register, and a sticky overrun flag records dropped words.
module sipo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter     DIRECTION  = "msb_first"
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  bit_vld_i,
  input  logic                  data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  input  logic                  clr_ovr_i
);

  localparam int              CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam bit              MSB_FIRST = (DIRECTION == "msb_first");

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   buff_q, buff_d;
  logic [DATA_WIDTH-1:0]   buff_shift;
  logic [DATA_WIDTH-1:0]   word_p0, word_d;
  logic                    vld_p0, vld_d;
  logic                    ovr_q, ovr_d;
  logic                    shift_en;
  logic                    word_done;
  logic                    xfer;
  logic                    load;
  logic                    drop;

  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] buff,
    input logic                  bit_in
  );
    if (MSB_FIRST) shift_in = {buff[DATA_WIDTH-2:0], bit_in};
    else           shift_in = {bit_in, buff[DATA_WIDTH-1:1]};
  endfunction

  // abort has priority over a bit arriving in the same cycle, so a word
  // finishing on an abort cycle is never offered
  assign shift_en   = (state_q == SHIFT) && bit_vld_i && !abort_i;
  assign buff_shift = shift_in(buff_q, data_i);
  assign word_done  = shift_en && (cnt_q == CNT_LAST);
  assign xfer       = vld_p0 && ready_i;
  assign load       = word_done && (!vld_p0 || xfer);
  assign drop       = word_done && vld_p0 && !ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buff_d  = buff_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          buff_d  = '0;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          buff_d  = '0;
        end else if (bit_vld_i) begin
          buff_d = buff_shift;
          cnt_d  = word_done ? '0 : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        buff_d  = '0;
      end
    endcase
  end

  // Output register: a new word is only taken when the slot is free or being emptied
  always_comb begin
    word_d = word_p0;
    vld_d  = vld_p0;
    if (load) begin
      word_d = buff_shift;
      vld_d  = 1'b1;
    end else if (xfer) begin
      vld_d  = 1'b0;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (drop)           ovr_d = 1'b1;
    else if (clr_ovr_i) ovr_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buff_q  <= '0;
      word_p0 <= '0;
      vld_p0  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buff_q  <= buff_d;
      word_p0 <= word_d;
      vld_p0  <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = word_p0;
  assign valid_o   = vld_p0;
  assign busy_o    = (state_q == SHIFT);
  assign overrun_o = ovr_q;

endmodule
